// File: rtl/mem_access_ctrl.sv
// Memory access controller between the execute and writeback stages: one 8-byte load/store
// at a time, range-checked against MEM_TOP, with a sticky halt on any address fault.
module mem_access_ctrl #(
    parameter int unsigned DATA_WID = 64,
    parameter int unsigned MEM_TOP  = 96
) (
    input  logic                CLK,
    input  logic                RST,

    input  logic                req_valid,
    input  logic                req_write,
    input  logic [DATA_WID-1:0] req_addr,
    input  logic [DATA_WID-1:0] req_data,
    output logic                req_ready,

    output logic [DATA_WID-1:0] mem_addr,
    output logic [DATA_WID-1:0] mem_write_data,
    output logic                mem_write_flag,
    output logic                mem_read_flag,
    input  logic [DATA_WID-1:0] mem_valM,
    input  logic                mem_error,

    output logic                resp_valid,
    output logic [DATA_WID-1:0] resp_data,
    output logic                resp_err,
    input  logic                resp_ready,

    output logic                halted
);

    // Highest legal start address of an 8-byte access; a memory under 8 bytes has none.
    localparam bit                  TooSmall  = (MEM_TOP < 7);
    localparam int unsigned         LastStart = TooSmall ? 0 : MEM_TOP - 7;
    localparam logic [DATA_WID-1:0] AddrLimit = DATA_WID'(LastStart);

    typedef enum logic [1:0] {
        StIdle,
        StIssue,
        StResp,
        StHalt
    } state_e;

    state_e              state_q, state_d;
    logic [DATA_WID-1:0] addr_q, addr_d;
    logic [DATA_WID-1:0] data_q, data_d;
    logic                write_q, write_d;
    logic [DATA_WID-1:0] resp_data_q, resp_data_d;
    logic                resp_err_q, resp_err_d;

    logic accept;
    logic addr_bad;
    logic consume;

    assign accept   = req_valid && (state_q == StIdle);
    assign consume  = resp_ready && (state_q == StResp);
    assign addr_bad = TooSmall || (req_addr > AddrLimit);

    // State register
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q     <= StIdle;
            addr_q      <= '0;
            data_q      <= '0;
            write_q     <= 1'b0;
            resp_data_q <= '0;
            resp_err_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            data_q      <= data_d;
            write_q     <= write_d;
            resp_data_q <= resp_data_d;
            resp_err_q  <= resp_err_d;
        end
    end

    // Next-state and datapath
    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        data_d      = data_q;
        write_d     = write_q;
        resp_data_d = resp_data_q;
        resp_err_d  = resp_err_q;

        unique case (state_q)
            StIdle: begin
                if (accept) begin
                    addr_d      = req_addr;
                    data_d      = req_data;
                    write_d     = req_write;
                    resp_data_d = '0;
                    if (addr_bad) begin
                        // Out-of-range accesses never reach the memory.
                        resp_err_d = 1'b1;
                        state_d    = StResp;
                    end else begin
                        resp_err_d = 1'b0;
                        state_d    = StIssue;
                    end
                end
            end
            StIssue: begin
                resp_err_d  = mem_error;
                resp_data_d = (write_q || mem_error) ? '0 : mem_valM;
                state_d     = StResp;
            end
            StResp: begin
                if (consume) begin
                    state_d = resp_err_q ? StHalt : StIdle;
                end
            end
            StHalt: begin
                state_d = StHalt;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // Outputs
    always_comb begin
        req_ready      = 1'b0;
        mem_write_flag = 1'b0;
        mem_read_flag  = 1'b0;
        resp_valid     = 1'b0;
        halted         = 1'b0;

        unique case (state_q)
            StIdle:  req_ready = 1'b1;
            StIssue: begin
                mem_write_flag = write_q;
                mem_read_flag  = !write_q;
            end
            StResp:  resp_valid = 1'b1;
            StHalt:  halted = 1'b1;
            default: req_ready = 1'b0;
        endcase
    end

    assign mem_addr       = addr_q;
    assign mem_write_data = data_q;
    assign resp_data      = resp_data_q;
    assign resp_err       = resp_err_q;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Directed bench for mem_access_ctrl with a byte-array memory model behind the memory port.
module tb_mem_access_ctrl;

    localparam int unsigned DataWid = 64;
    localparam int unsigned MemTop  = 96;

    logic               CLK = 1'b0;
    logic               RST = 1'b1;
    logic               req_valid = 1'b0;
    logic               req_write = 1'b0;
    logic [DataWid-1:0] req_addr = '0;
    logic [DataWid-1:0] req_data = '0;
    logic               req_ready;
    logic [DataWid-1:0] mem_addr;
    logic [DataWid-1:0] mem_write_data;
    logic               mem_write_flag;
    logic               mem_read_flag;
    logic [DataWid-1:0] mem_valM;
    logic               mem_error;
    logic               resp_valid;
    logic [DataWid-1:0] resp_data;
    logic               resp_err;
    logic               resp_ready = 1'b0;
    logic               halted;

    logic               err_force = 1'b0;
    logic               init_req  = 1'b1;
    logic [7:0]         mem [0:MemTop];
    int                 strobes = 0;
    int                 cyc = 0;
    int                 last_acc = 0;
    int                 prev_acc = 0;
    int                 n_checks = 0;
    int                 n_fail = 0;

    mem_access_ctrl #(
        .DATA_WID (DataWid),
        .MEM_TOP  (MemTop)
    ) dut (
        .CLK            (CLK),
        .RST            (RST),
        .req_valid      (req_valid),
        .req_write      (req_write),
        .req_addr       (req_addr),
        .req_data       (req_data),
        .req_ready      (req_ready),
        .mem_addr       (mem_addr),
        .mem_write_data (mem_write_data),
        .mem_write_flag (mem_write_flag),
        .mem_read_flag  (mem_read_flag),
        .mem_valM       (mem_valM),
        .mem_error      (mem_error),
        .resp_valid     (resp_valid),
        .resp_data      (resp_data),
        .resp_err       (resp_err),
        .resp_ready     (resp_ready),
        .halted         (halted)
    );

    always #5 CLK = ~CLK;

    assign mem_error = err_force;

    // Memory model: byte i initialised to i, little-endian 8-byte words.
    always @(posedge CLK) begin
        if (init_req) begin
            for (int i = 0; i <= int'(MemTop); i++) mem[i] <= 8'(i);
        end else if (mem_write_flag && mem_addr <= 64'(MemTop - 7)) begin
            for (int b = 0; b < 8; b++) mem[int'(mem_addr[6:0]) + b] <= mem_write_data[8*b +: 8];
        end
    end

    always_comb begin
        mem_valM = '0;
        if (mem_addr <= 64'(MemTop - 7)) begin
            for (int b = 0; b < 8; b++) mem_valM[8*b +: 8] = mem[int'(mem_addr[6:0]) + b];
        end
    end

    always @(posedge CLK) begin
        cyc <= cyc + 1;
        if (mem_read_flag || mem_write_flag) strobes <= strobes + 1;
        if (!RST && req_valid && req_ready) begin
            prev_acc <= last_acc;
            last_acc <= cyc;
        end
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%016h expected 0x%016h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    // Present a request and return #1 after the edge that accepts it.
    task automatic send(input logic w, input logic [63:0] a, input logic [63:0] d);
        int n;
        req_valid = 1'b1;
        req_write = w;
        req_addr  = a;
        req_data  = d;
        n = 0;
        while (!req_ready && n < 20) begin
            step();
            n++;
        end
        check("accept_timeout", 64'(n < 20), 64'd1);
        step();
        req_valid = 1'b0;
    endtask

    task automatic wait_resp();
        int n;
        n = 0;
        while (!resp_valid && n < 20) begin
            step();
            n++;
        end
        check("resp_timeout", 64'(n < 20), 64'd1);
    endtask

    task automatic consume();
        resp_ready = 1'b1;
        step();
        resp_ready = 1'b0;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_ready"}, 64'(req_ready), 64'd1);
        check({tag, "_flags"}, {62'd0, mem_write_flag, mem_read_flag}, 64'd0);
        check({tag, "_addr"}, mem_addr, 64'd0);
        check({tag, "_wdata"}, mem_write_data, 64'd0);
        check({tag, "_resp"}, {62'd0, resp_valid, resp_err}, 64'd0);
        check({tag, "_rdata"}, resp_data, 64'd0);
        check({tag, "_halted"}, 64'(halted), 64'd0);
    endtask

    initial begin
        int s0;
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int s0;
        step();
        init_req = 1'b0;
        step();
        check_reset_outputs("reset");
        RST = 1'b0;
        step();

        // Store then load back.
        s0 = strobes;
        send(1'b1, 64'h10, 64'h1122334455667788);
        check("st_issue_flags", {62'd0, mem_write_flag, mem_read_flag}, 64'd2);
        check("st_issue_addr", mem_addr, 64'h10);
        check("st_issue_wdata", mem_write_data, 64'h1122334455667788);
        check("st_issue_novalid", 64'(resp_valid), 64'd0);
        step();
        check("st_resp", {62'd0, resp_valid, resp_err}, 64'd2);
        check("st_rdata", resp_data, 64'd0);
        check("st_strobes", 64'(strobes - s0), 64'd1);
        consume();
        check("st_valid_drop", 64'(resp_valid), 64'd0);
        check("st_hold_addr", mem_addr, 64'h10);

        s0 = strobes;
        send(1'b0, 64'h10, 64'h0);
        check("ld_issue_flags", {62'd0, mem_write_flag, mem_read_flag}, 64'd1);
        step();
        check("ld_resp", {62'd0, resp_valid, resp_err}, 64'd2);
        check("ld_data", resp_data, 64'h1122334455667788);
        check("ld_strobes", 64'(strobes - s0), 64'd1);
        consume();

        // Backpressure with a stray request held up meanwhile.
        s0 = strobes;
        send(1'b0, 64'h10, 64'h0);
        req_valid = 1'b1;
        req_addr  = 64'h20;
        step();
        for (int i = 0; i < 5; i++) begin
            check("bp_valid", 64'(resp_valid), 64'd1);
            check("bp_data", resp_data, 64'h1122334455667788);
            check("bp_ready", 64'(req_ready), 64'd0);
            step();
        end
        check("bp_strobes", 64'(strobes - s0), 64'd1);
        req_valid = 1'b0;
        consume();

        // Highest legal address.
        send(1'b0, 64'd89, 64'h0);
        wait_resp();
        check("top_data", resp_data, 64'h605F5E5D5C5B5A59);
        check("top_err", 64'(resp_err), 64'd0);
        consume();

        // Back-to-back loads with resp_ready held high.
        resp_ready = 1'b1;
        send(1'b0, 64'h0, 64'h0);
        req_valid = 1'b1;
        req_write = 1'b0;
        req_addr  = 64'h8;
        step();
        check("b2b_data0", resp_data, 64'h0706050403020100);
        step();
        check("b2b_ready", 64'(req_ready), 64'd1);
        step();
        req_valid = 1'b0;
        check("b2b_gap", 64'(last_acc - prev_acc), 64'd3);
        step();
        check("b2b_valid1", 64'(resp_valid), 64'd1);
        check("b2b_data1", resp_data, 64'h0F0E0D0C0B0A0908);
        step();
        resp_ready = 1'b0;
        check("b2b_idle", 64'(req_ready), 64'd1);

        // Memory error during a store's issue cycle.
        send(1'b1, 64'h08, 64'hDEADBEEFCAFEF00D);
        err_force = 1'b1;
        step();
        err_force = 1'b0;
        check("merr_err", 64'(resp_err), 64'd1);
        check("merr_data", resp_data, 64'd0);
        consume();
        check("merr_halt", {62'd0, halted, req_ready}, 64'd2);

        // Reset out of HALT.
        RST = 1'b1;
        step();
        check_reset_outputs("rst_halt");
        RST = 1'b0;
        step();

        // Out-of-range load.
        s0 = strobes;
        send(1'b0, 64'd90, 64'h0);
        check("oor_flags", {62'd0, mem_write_flag, mem_read_flag}, 64'd0);
        check("oor_resp", {62'd0, resp_valid, resp_err}, 64'd3);
        check("oor_data", resp_data, 64'd0);
        consume();
        req_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            check("oor_halt", {62'd0, halted, req_ready}, 64'd2);
            step();
        end
        req_valid = 1'b0;
        check("oor_strobes", 64'(strobes - s0), 64'd0);

        RST = 1'b1;
        step();
        RST = 1'b0;

        // Reset during ISSUE aborts the store's response.
        send(1'b1, 64'h18, 64'hA5A5A5A5A5A5A5A5);
        RST = 1'b1;
        step();
        RST = 1'b0;
        check_reset_outputs("rst_issue");
        for (int i = 0; i < 3; i++) begin
            step();
            check("rst_noresp", 64'(resp_valid), 64'd0);
        end

        send(1'b1, 64'h20, 64'h0123456789ABCDEF);
        wait_resp();
        check("post_st_err", 64'(resp_err), 64'd0);
        consume();
        send(1'b0, 64'h20, 64'h0);
        wait_resp();
        check("post_ld_data", resp_data, 64'h0123456789ABCDEF);
        consume();

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
